// File: rtl/adbg_core_dbg_pkg.sv
// Shared definitions for the per-core debug responder: register map, bit
// positions inside CTRL/HIT, FSM and access-decode encodings.
package adbg_core_dbg_pkg;

  localparam logic [15:0] ADDR_CTRL = 16'h0000;
  localparam logic [15:0] ADDR_HIT  = 16'h0004;
  localparam logic [15:0] ADDR_NPC  = 16'h2000;
  localparam logic [15:0] ADDR_PPC  = 16'h2004;

  localparam int CTRL_HALTED = 0;
  localparam int CTRL_SSTE   = 1;

  localparam int HIT_SSTH = 0;
  localparam int HIT_EBRK = 1;
  localparam int HIT_ERR  = 2;
  localparam int HIT_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RF_REQ   = 3'd1,
    ST_RF_ERR   = 3'd2,
    ST_RF_CAP   = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAIT_LOW = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ACC_NONE = 3'd0,
    ACC_CTRL = 3'd1,
    ACC_HIT  = 3'd2,
    ACC_NPC  = 3'd3,
    ACC_PPC  = 3'd4,
    ACC_GPR  = 3'd5
  } acc_e;

  // Word-aligned address falls inside [base, base + 4*num).
  function automatic logic in_gpr_window(input logic [15:0] addr,
                                         input logic [15:0] base,
                                         input int unsigned num);
    logic [13:0] off;
    off = addr[15:2] - base[15:2];
    return (addr[15:2] >= base[15:2]) && ({18'd0, off} < num);
  endfunction

endpackage

// File: rtl/adbg_core_dbg_if.sv
// Debug-interface CPU port lane: request/ack bus plus stall and breakpoint.
interface adbg_core_dbg_if;
  logic        dbg_stb_i;
  logic        dbg_we_i;
  logic [15:0] dbg_addr_i;
  logic [31:0] dbg_data_i;
  logic [31:0] dbg_data_o;
  logic        dbg_ack_o;
  logic        dbg_stall_i;
  logic        dbg_bp_o;

  modport master (
    output dbg_stb_i, dbg_we_i, dbg_addr_i, dbg_data_i, dbg_stall_i,
    input  dbg_data_o, dbg_ack_o, dbg_bp_o
  );

  modport slave (
    input  dbg_stb_i, dbg_we_i, dbg_addr_i, dbg_data_i, dbg_stall_i,
    output dbg_data_o, dbg_ack_o, dbg_bp_o
  );
endinterface

// File: rtl/adbg_core_dbg_unit.sv
// CPU-side debug responder for one core: decodes debug register accesses,
// reaches GPR/NPC through the core register-file port and raises halt.
module adbg_core_dbg_unit
  import adbg_core_dbg_pkg::*;
#(
  parameter logic [15:0] GPR_BASE   = 16'h0400,
  parameter int unsigned NUM_GPR    = 32,
  parameter logic        RESET_SSTE = 1'b0
) (
  input  logic           cpu_clk_i,
  input  logic           cpu_rstn_i,
  adbg_core_dbg_if.slave dbg,
  output logic           core_halt_o,
  input  logic           core_halted_i,
  input  logic           core_ebreak_i,
  input  logic           core_retire_i,
  output logic           core_rf_req_o,
  output logic           core_rf_we_o,
  output logic [4:0]     core_rf_addr_o,
  output logic [31:0]    core_rf_wdata_o,
  input  logic [31:0]    core_rf_rdata_i,
  input  logic [31:0]    core_npc_i,
  input  logic [31:0]    core_ppc_i,
  output logic           core_npc_we_o
);

  state_e            state_r, state_n;
  acc_e              acc_s;
  logic [15:0]       addr_w_s;
  logic [4:0]        gpr_idx_s;
  logic              unused_addr_lsb_s;

  logic              sste_r, sste_n;
  logic [HIT_W-1:0]  hit_r, hit_n, hit_set_s, hit_clr_s, ev_mask_s;
  logic              pend_r, pend_n, ev_ssth_s;
  logic              halt_r;
  logic [31:0]       data_r, data_n;
  logic              ack_r;
  logic              acc_rd_r, acc_rd_n;
  logic              rf_ok_r, rf_ok_n;
  logic              rf_req_r, rf_req_n, rf_we_r, rf_we_n, npc_we_r, npc_we_n;
  logic [4:0]        rf_addr_r, rf_addr_n;
  logic [31:0]       rf_wdata_r, rf_wdata_n;
  logic [31:0]       ctrl_rd_s;

  assign addr_w_s          = {dbg.dbg_addr_i[15:2], 2'b00};
  assign unused_addr_lsb_s = ^dbg.dbg_addr_i[1:0];
  // Only the low five bits of the word offset select the GPR.
  assign gpr_idx_s         = dbg.dbg_addr_i[6:2] - GPR_BASE[6:2];
  assign ctrl_rd_s         = {30'd0, sste_r, core_halted_i};

  // Address decode into access class.
  always_comb begin
    acc_s = ACC_NONE;
    if (addr_w_s == ADDR_CTRL) begin
      acc_s = ACC_CTRL;
    end else if (addr_w_s == ADDR_HIT) begin
      acc_s = ACC_HIT;
    end else if (addr_w_s == ADDR_NPC) begin
      acc_s = ACC_NPC;
    end else if (addr_w_s == ADDR_PPC) begin
      acc_s = ACC_PPC;
    end else if (in_gpr_window(addr_w_s, GPR_BASE, NUM_GPR)) begin
      acc_s = ACC_GPR;
    end else begin
      acc_s = ACC_NONE;
    end
  end

  // Access FSM next state, register side effects and core strobes.
  always_comb begin
    state_n    = state_r;
    sste_n     = sste_r;
    data_n     = data_r;
    acc_rd_n   = acc_rd_r;
    rf_ok_n    = rf_ok_r;
    hit_set_s  = 3'b000;
    hit_clr_s  = 3'b000;
    rf_req_n   = 1'b0;
    rf_we_n    = 1'b0;
    rf_addr_n  = 5'd0;
    rf_wdata_n = 32'd0;
    npc_we_n   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (dbg.dbg_stb_i) begin
          acc_rd_n = ~dbg.dbg_we_i;
          rf_ok_n  = core_halted_i;
          state_n  = ST_ACK;
          case (acc_s)
            ACC_CTRL: begin
              if (dbg.dbg_we_i) sste_n = dbg.dbg_data_i[CTRL_SSTE];
              else              data_n = ctrl_rd_s;
            end
            ACC_HIT: begin
              if (dbg.dbg_we_i) hit_clr_s = dbg.dbg_data_i[HIT_W-1:0];
              else              data_n    = {29'd0, hit_r};
            end
            ACC_NPC: begin
              if (core_halted_i) begin
                if (dbg.dbg_we_i) begin
                  npc_we_n   = 1'b1;
                  rf_wdata_n = dbg.dbg_data_i;
                end else begin
                  data_n = core_npc_i;
                end
              end else begin
                hit_set_s[HIT_ERR] = 1'b1;
                if (dbg.dbg_we_i) data_n = data_r;
                else              data_n = 32'd0;
              end
            end
            ACC_PPC: begin
              if (dbg.dbg_we_i) data_n = data_r;
              else              data_n = core_ppc_i;
            end
            ACC_GPR: begin
              if (core_halted_i) begin
                rf_req_n   = 1'b1;
                rf_we_n    = dbg.dbg_we_i;
                rf_addr_n  = gpr_idx_s;
                rf_wdata_n = dbg.dbg_we_i ? dbg.dbg_data_i : 32'd0;
                state_n    = ST_RF_REQ;
              end else begin
                hit_set_s[HIT_ERR] = 1'b1;
                state_n            = ST_RF_ERR;
              end
            end
            default: begin
              if (dbg.dbg_we_i) data_n = data_r;
              else              data_n = 32'd0;
            end
          endcase
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RF_REQ:   state_n = ST_RF_CAP;
      ST_RF_ERR:   state_n = ST_RF_CAP;
      ST_RF_CAP: begin
        // Refused accesses keep the GPR ack latency but read back zero.
        if (acc_rd_r) data_n = rf_ok_r ? core_rf_rdata_i : 32'd0;
        else          data_n = data_r;
        state_n = ST_ACK;
      end
      ST_ACK:      state_n = ST_WAIT_LOW;
      ST_WAIT_LOW: begin
        if (dbg.dbg_stb_i) state_n = ST_WAIT_LOW;
        else               state_n = ST_IDLE;
      end
      default:     state_n = ST_IDLE;
    endcase
  end

  // Debug events; a new event overrides a coincident write-1-clear.
  always_comb begin
    ev_ssth_s           = core_retire_i & sste_r & ~dbg.dbg_stall_i;
    ev_mask_s           = 3'b000;
    ev_mask_s[HIT_EBRK] = core_ebreak_i;
    ev_mask_s[HIT_SSTH] = ev_ssth_s;
    hit_n  = (hit_r & ~hit_clr_s) | hit_set_s | ev_mask_s;
    pend_n = ~dbg.dbg_stall_i & (pend_r | core_ebreak_i | ev_ssth_s);
  end

  // State and output registers.
  always_ff @(posedge cpu_clk_i) begin
    if (!cpu_rstn_i) begin
      state_r    <= ST_IDLE;
      sste_r     <= RESET_SSTE;
      hit_r      <= 3'b000;
      pend_r     <= 1'b0;
      halt_r     <= 1'b0;
      data_r     <= 32'd0;
      ack_r      <= 1'b0;
      acc_rd_r   <= 1'b0;
      rf_ok_r    <= 1'b0;
      rf_req_r   <= 1'b0;
      rf_we_r    <= 1'b0;
      rf_addr_r  <= 5'd0;
      rf_wdata_r <= 32'd0;
      npc_we_r   <= 1'b0;
    end else begin
      state_r    <= state_n;
      sste_r     <= sste_n;
      hit_r      <= hit_n;
      pend_r     <= pend_n;
      halt_r     <= dbg.dbg_stall_i | pend_n;
      data_r     <= data_n;
      ack_r      <= (state_n == ST_ACK);
      acc_rd_r   <= acc_rd_n;
      rf_ok_r    <= rf_ok_n;
      rf_req_r   <= rf_req_n;
      rf_we_r    <= rf_we_n;
      rf_addr_r  <= rf_addr_n;
      rf_wdata_r <= rf_wdata_n;
      npc_we_r   <= npc_we_n;
    end
  end

  assign dbg.dbg_data_o  = data_r;
  assign dbg.dbg_ack_o   = ack_r;
  assign dbg.dbg_bp_o    = pend_r;
  assign core_halt_o     = halt_r;
  assign core_rf_req_o   = rf_req_r;
  assign core_rf_we_o    = rf_we_r;
  assign core_rf_addr_o  = rf_addr_r;
  assign core_rf_wdata_o = rf_wdata_r;
  assign core_npc_we_o   = npc_we_r;

endmodule

// File: tb/tb_adbg_core_dbg_unit.sv
// Self-checking bench for adbg_core_dbg_unit: directed scenarios plus random
// accesses/events against a register-map-level reference model.
module tb_adbg_core_dbg_unit;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  adbg_core_dbg_if dbg_if ();

  logic        core_halt, core_halted, core_ebreak, core_retire;
  logic        rf_req, rf_we, npc_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata, rf_rdata, npc_core, ppc;

  adbg_core_dbg_unit dut (
    .cpu_clk_i      (clk),
    .cpu_rstn_i     (rstn),
    .dbg            (dbg_if),
    .core_halt_o    (core_halt),
    .core_halted_i  (core_halted),
    .core_ebreak_i  (core_ebreak),
    .core_retire_i  (core_retire),
    .core_rf_req_o  (rf_req),
    .core_rf_we_o   (rf_we),
    .core_rf_addr_o (rf_addr),
    .core_rf_wdata_o(rf_wdata),
    .core_rf_rdata_i(rf_rdata),
    .core_npc_i     (npc_core),
    .core_ppc_i     (ppc),
    .core_npc_we_o  (npc_we)
  );

  // Core stand-in: register file answers a cycle after the strobe.
  logic [31:0] core_mem [32];
  always @(posedge clk) begin
    if (rf_req) begin
      if (rf_we) core_mem[rf_addr] <= rf_wdata;
      else       rf_rdata <= core_mem[rf_addr];
    end
    if (npc_we) npc_core <= rf_wdata;
  end

  // Reference model of the debug-visible state.
  logic        m_sste;
  logic [2:0]  m_hit;
  logic        m_pend;
  logic [31:0] m_npc;
  logic [31:0] m_gpr [32];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One debug access; starts and ends on a falling edge.
  task automatic do_acc(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                        input int hold, input logic eb);
    logic [15:0] a;
    logic        is_gpr, err;
    int          gi, exp_k, exp_req, exp_npcw;
    int          ack_k, acks, reqs, req_k, npcws;
    logic [31:0] exp_d, got_d, q_wd, npc_wd;
    logic [4:0]  q_addr;
    logic        q_we;
    logic [2:0]  clr;
    a        = {addr[15:2], 2'b00};
    is_gpr   = (a >= 16'h0400) && (a < 16'h0480);
    gi       = (int'(a) - 32'h400) / 4;
    exp_k    = is_gpr ? 3 : 1;
    exp_req  = 0;
    exp_npcw = 0;
    exp_d    = 32'd0;
    err      = 1'b0;
    clr      = 3'b000;
    if (a == 16'h0000) begin
      if (we) m_sste = wdata[1];
      else    exp_d = {30'd0, m_sste, core_halted};
    end else if (a == 16'h0004) begin
      if (we) clr = wdata[2:0];
      else    exp_d = {29'd0, m_hit};
    end else if (a == 16'h2000) begin
      if (!core_halted) err = 1'b1;
      else if (we) begin exp_npcw = 1; m_npc = wdata; end
      else exp_d = m_npc;
    end else if (a == 16'h2004) begin
      exp_d = we ? 32'd0 : ppc;
    end else if (is_gpr) begin
      if (!core_halted) err = 1'b1;
      else begin
        exp_req = 1;
        if (we) m_gpr[gi] = wdata;
        else    exp_d = m_gpr[gi];
      end
    end
    m_hit  = (m_hit & ~clr) | {err, eb, 1'b0};
    m_pend = !dbg_if.dbg_stall_i & (m_pend | eb);

    dbg_if.dbg_stb_i  = 1'b1;
    dbg_if.dbg_we_i   = we;
    dbg_if.dbg_addr_i = addr;
    dbg_if.dbg_data_i = wdata;
    core_ebreak       = eb;
    ack_k = 0; acks = 0; reqs = 0; req_k = 0; npcws = 0;
    got_d = 32'd0; q_wd = 32'd0; npc_wd = 32'd0; q_addr = 5'd0; q_we = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      core_ebreak = 1'b0;
      if (rf_req) begin
        reqs++;
        if (req_k == 0) req_k = k;
        q_addr = rf_addr; q_we = rf_we; q_wd = rf_wdata;
      end
      if (npc_we) begin npcws++; npc_wd = rf_wdata; end
      if (dbg_if.dbg_ack_o) begin
        acks++;
        if (ack_k == 0) begin ack_k = k; got_d = dbg_if.dbg_data_o; end
      end
      if (ack_k != 0 && k == ack_k + hold) dbg_if.dbg_stb_i = 1'b0;
      if (ack_k != 0 && k >= ack_k + hold + 3) break;
    end
    dbg_if.dbg_stb_i = 1'b0;

    check_eq("ack_latency", 32'(ack_k), 32'(exp_k));
    check_eq("ack_count", 32'(acks), 32'd1);
    if (!we) check_eq("read_data", got_d, exp_d);
    check_eq("rf_req_count", 32'(reqs), 32'(exp_req));
    if (exp_req != 0) begin
      check_eq("rf_req_cycle", 32'(req_k), 32'd1);
      check_eq("rf_addr", {27'd0, q_addr}, 32'(gi));
      check_eq("rf_we", {31'd0, q_we}, {31'd0, we});
      if (we) check_eq("rf_wdata", q_wd, wdata);
    end
    check_eq("npc_we_count", 32'(npcws), 32'(exp_npcw));
    if (exp_npcw != 0) check_eq("npc_wdata", npc_wd, wdata);
    check_eq("halt_after_acc", {31'd0, core_halt}, {31'd0, dbg_if.dbg_stall_i | m_pend});
    check_eq("bp_after_acc", {31'd0, dbg_if.dbg_bp_o}, {31'd0, m_pend});
  endtask

  // One cycle of core events with the stall level given.
  task automatic ev_cycle(input logic eb, input logic ret, input logic st);
    logic ssth;
    core_ebreak        = eb;
    core_retire        = ret;
    dbg_if.dbg_stall_i = st;
    @(negedge clk);
    core_ebreak = 1'b0;
    core_retire = 1'b0;
    ssth = ret & m_sste & !st;
    if (eb)   m_hit[1] = 1'b1;
    if (ssth) m_hit[0] = 1'b1;
    m_pend = !st & (m_pend | eb | ssth);
    check_eq("ev_bp", {31'd0, dbg_if.dbg_bp_o}, {31'd0, m_pend});
    check_eq("ev_halt", {31'd0, core_halt}, {31'd0, st | m_pend});
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ack"},    {31'd0, dbg_if.dbg_ack_o}, 32'd0);
    check_eq({tag, "_data"},   dbg_if.dbg_data_o, 32'd0);
    check_eq({tag, "_bp"},     {31'd0, dbg_if.dbg_bp_o}, 32'd0);
    check_eq({tag, "_halt"},   {31'd0, core_halt}, 32'd0);
    check_eq({tag, "_rfreq"},  {31'd0, rf_req}, 32'd0);
    check_eq({tag, "_rfwe"},   {31'd0, rf_we}, 32'd0);
    check_eq({tag, "_rfaddr"}, {27'd0, rf_addr}, 32'd0);
    check_eq({tag, "_rfwd"},   rf_wdata, 32'd0);
    check_eq({tag, "_npcwe"},  {31'd0, npc_we}, 32'd0);
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] unm [6];
    logic [15:0] a;
    unm = '{16'h0008, 16'h03FC, 16'h0480, 16'h2008, 16'h1000, 16'hFFFC};
    case ($urandom_range(0, 7))
      0:       a = 16'h0000;
      1:       a = 16'h0004;
      2:       a = 16'h2000;
      3:       a = 16'h2004;
      4, 5:    a = 16'(16'h0400 + 4 * $urandom_range(0, 31));
      6:       a = unm[$urandom_range(0, 5)];
      default: a = ($urandom_range(0, 1) == 0) ? 16'h0400 : 16'h047C;
    endcase
    a[1:0] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  initial begin
    int acks;
    dbg_if.dbg_stb_i   = 1'b0;
    dbg_if.dbg_we_i    = 1'b0;
    dbg_if.dbg_addr_i  = 16'h0000;
    dbg_if.dbg_data_i  = 32'd0;
    dbg_if.dbg_stall_i = 1'b0;
    core_halted = 1'b0;
    core_ebreak = 1'b0;
    core_retire = 1'b0;
    ppc = $urandom;
    m_sste = 1'b0; m_hit = 3'b000; m_pend = 1'b0; m_npc = 32'd0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Reset values of the local registers.
    do_acc(1'b0, 16'h0000, 32'd0, 0, 1'b0);
    do_acc(1'b0, 16'h0004, 32'd0, 0, 1'b0);

    // CTRL write/read with the core halted.
    core_halted = 1'b1;
    do_acc(1'b1, 16'h0000, 32'h0000_0002, 0, 1'b0);
    do_acc(1'b0, 16'h0000, 32'd0, 0, 1'b0);

    // Fill every GPR and NPC through the debug port.
    for (int i = 0; i < 32; i++) do_acc(1'b1, 16'(16'h0400 + 4 * i), $urandom, 0, 1'b0);
    do_acc(1'b1, 16'h2000, $urandom, 0, 1'b0);
    do_acc(1'b0, 16'h2000, 32'd0, 0, 1'b0);
    do_acc(1'b0, 16'h2004, 32'd0, 0, 1'b0);

    do_acc(1'b1, 16'h0414, 32'hA5A5_0001, 0, 1'b0);
    do_acc(1'b0, 16'h0414, 32'd0, 0, 1'b0);

    // Not halted: GPR refused, ERR raised, then cleared.
    core_halted = 1'b0;
    do_acc(1'b0, 16'h040C, 32'd0, 0, 1'b0);
    do_acc(1'b0, 16'h0004, 32'd0, 0, 1'b0);
    do_acc(1'b1, 16'h0004, 32'h0000_0004, 0, 1'b0);
    do_acc(1'b0, 16'h0004, 32'd0, 0, 1'b0);

    // Strobe held long after the ack.
    do_acc(1'b0, 16'h0000, 32'd0, 10, 1'b0);

    // ebreak raises halt/bp; stall drops bp but keeps halt.
    ev_cycle(1'b1, 1'b0, 1'b0);
    ev_cycle(1'b0, 1'b0, 1'b1);
    ev_cycle(1'b0, 1'b0, 1'b1);
    do_acc(1'b0, 16'h0004, 32'd0, 0, 1'b0);
    do_acc(1'b1, 16'h0004, 32'h0000_0007, 0, 1'b0);

    // Single-step, then simultaneous ebreak+retire.
    ev_cycle(1'b0, 1'b0, 1'b0);
    ev_cycle(1'b0, 1'b1, 1'b0);
    ev_cycle(1'b0, 1'b0, 1'b1);
    do_acc(1'b1, 16'h0004, 32'h0000_0003, 0, 1'b0);
    ev_cycle(1'b1, 1'b1, 1'b0);
    do_acc(1'b0, 16'h0004, 32'd0, 0, 1'b0);

    // W1C coinciding with a new ebreak: the event wins.
    do_acc(1'b1, 16'h0004, 32'h0000_0003, 0, 1'b1);
    do_acc(1'b0, 16'h0004, 32'd0, 0, 1'b0);

    // Random event traffic.
    for (int i = 0; i < 40; i++)
      ev_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    do_acc(1'b0, 16'h0004, 32'd0, 0, 1'b0);

    // Random accesses.
    for (int i = 0; i < 80; i++) begin
      core_halted        = ($urandom_range(0, 1) == 1);
      dbg_if.dbg_stall_i = ($urandom_range(0, 3) == 0);
      do_acc($urandom_range(0, 1) == 1, rand_addr(), $urandom, int'($urandom_range(0, 3)),
             $urandom_range(0, 7) == 0);
    end

    // Reset while a GPR read sits in the capture state.
    core_halted        = 1'b1;
    dbg_if.dbg_stall_i = 1'b0;
    dbg_if.dbg_stb_i   = 1'b1;
    dbg_if.dbg_we_i    = 1'b0;
    dbg_if.dbg_addr_i  = 16'h041C;
    @(negedge clk);
    check_eq("midrst_req", {31'd0, rf_req}, 32'd1);
    @(negedge clk);
    check_eq("midrst_noack_cap", {31'd0, dbg_if.dbg_ack_o}, 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    check_outputs_zero("midrst");
    rstn = 1'b1;
    dbg_if.dbg_stb_i = 1'b0;
    m_sste = 1'b0; m_hit = 3'b000; m_pend = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (dbg_if.dbg_ack_o) acks++;
    end
    check_eq("midrst_ack_count", 32'(acks), 32'd0);
    do_acc(1'b0, 16'h0000, 32'd0, 0, 1'b0);
    do_acc(1'b0, 16'h041C, 32'd0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
